// File: rtl/VX_gpu_pkg.sv
// Shared types for the KMU CTA scheduler: FSM states, grid coordinates and
// the credit-counter width helper.
package VX_gpu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDispatch,
        StDrain,
        StDone
    } kmu_cta_state_e;

    // z first so the struct overlays launch_grid {z, y, x} bit-for-bit
    typedef struct packed {
        logic [31:0] z;
        logic [31:0] y;
        logic [31:0] x;
    } kmu_grid_t;

    function automatic int unsigned kmu_cta_cred_w(input int unsigned max_ctas);
        return $clog2(max_ctas + 1);
    endfunction

endpackage

// File: rtl/vx_kmu_rr_pick.sv
// Combinational round-robin selector: first eligible index at or after rr_ptr,
// wrapping around the vector.
module vx_kmu_rr_pick #(
    parameter int unsigned NUM = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [NUM-1:0] eligible,
    input  logic [IDW-1:0] rr_ptr,
    output logic [IDW-1:0] grant,
    output logic           any
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM; i++) begin
            idx = IDW'((32'(rr_ptr) + i) % NUM);
            if (!any && eligible[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_kmu_cta_scheduler.sv
// CTA dispatcher for one kernel launch: walks the grid z-fastest, issues one CTA
// per cycle to a round-robin core with free credits and reports completion.
module vx_kmu_cta_scheduler
    import VX_gpu_pkg::*;
#(
    parameter int unsigned NUM_CORES         = 4,
    parameter int unsigned MAX_CTAS_PER_CORE = 2,
    parameter int unsigned CORE_IDW          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 launch_valid,
    output logic                 launch_ready,
    input  logic [95:0]          launch_grid,
    output logic                 cta_valid,
    input  logic                 cta_ready,
    output logic [CORE_IDW-1:0]  cta_core,
    output logic [31:0]          cta_x,
    output logic [31:0]          cta_y,
    output logic [31:0]          cta_z,
    output logic [31:0]          cta_id,
    input  logic [NUM_CORES-1:0] core_retire,
    output logic                 kernel_done,
    output logic                 busy,
    output logic                 err_underflow
);

    localparam int unsigned KMU_CTA_CRED_W = kmu_cta_cred_w(MAX_CTAS_PER_CORE);
    localparam logic [KMU_CTA_CRED_W-1:0] CRED_MAX = KMU_CTA_CRED_W'(MAX_CTAS_PER_CORE);

    kmu_cta_state_e            state_q, state_d;
    kmu_grid_t                 grid_q, grid_d;
    kmu_grid_t                 pos_q, pos_d;
    logic [31:0]               id_q, id_d;
    logic [KMU_CTA_CRED_W-1:0] outstanding_q [NUM_CORES];
    logic [KMU_CTA_CRED_W-1:0] outstanding_d [NUM_CORES];
    logic [CORE_IDW-1:0]       rr_q, rr_d, lock_core_q, lock_core_d, grant;
    logic                      lock_q, lock_d, err_q, err_d, any;
    logic [NUM_CORES-1:0]      eligible, issue_hit, retire_ok, underflow;
    logic                      handshake, last_cta, all_idle;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            eligible[i] = outstanding_q[i] < CRED_MAX;
        end
    end

    vx_kmu_rr_pick #(
        .NUM (NUM_CORES),
        .IDW (CORE_IDW)
    ) u_rr_pick (
        .eligible (eligible),
        .rr_ptr   (rr_q),
        .grant    (grant),
        .any      (any)
    );

    // A stalled offer keeps its core even if retires change the pick.
    assign cta_valid     = (state_q == StDispatch) && (lock_q || any);
    assign cta_core      = lock_q ? lock_core_q : grant;
    assign cta_x         = pos_q.x;
    assign cta_y         = pos_q.y;
    assign cta_z         = pos_q.z;
    assign cta_id        = id_q;
    assign handshake     = cta_valid && cta_ready;
    assign launch_ready  = (state_q == StIdle);
    assign busy          = (state_q != StIdle);
    assign kernel_done   = (state_q == StDone);
    assign err_underflow = err_q;
    assign last_cta      = (pos_q.x == grid_q.x - 32'd1) && (pos_q.y == grid_q.y - 32'd1) &&
                           (pos_q.z == grid_q.z - 32'd1);

    always_comb begin
        issue_hit = '0;
        retire_ok = '0;
        underflow = '0;
        all_idle  = 1'b1;
        for (int i = 0; i < NUM_CORES; i++) begin
            issue_hit[i]     = handshake && (cta_core == CORE_IDW'(i));
            retire_ok[i]     = core_retire[i] && (outstanding_q[i] != '0);
            underflow[i]     = core_retire[i] && (outstanding_q[i] == '0);
            outstanding_d[i] = outstanding_q[i];
            if (issue_hit[i] && !retire_ok[i]) begin
                outstanding_d[i] = outstanding_q[i] + 1'b1;
            end else if (!issue_hit[i] && retire_ok[i]) begin
                outstanding_d[i] = outstanding_q[i] - 1'b1;
            end
            if (outstanding_d[i] != '0) begin
                all_idle = 1'b0;
            end
        end
        err_d = err_q | (|underflow);
    end

    always_comb begin
        state_d     = state_q;
        grid_d      = grid_q;
        pos_d       = pos_q;
        id_d        = id_q;
        rr_d        = rr_q;
        lock_d      = lock_q;
        lock_core_d = lock_core_q;
        case (state_q)
            StIdle: begin
                if (launch_valid) begin
                    grid_d = launch_grid;
                    if ((launch_grid[31:0] == '0) || (launch_grid[63:32] == '0) ||
                        (launch_grid[95:64] == '0)) begin
                        state_d = StDone;
                    end else begin
                        pos_d   = '0;
                        id_d    = '0;
                        lock_d  = 1'b0;
                        state_d = StDispatch;
                    end
                end
            end
            StDispatch: begin
                if (handshake) begin
                    lock_d  = 1'b0;
                    rr_d    = (32'(cta_core) == NUM_CORES - 1) ? '0 : cta_core + 1'b1;
                    id_d    = id_q + 32'd1;
                    pos_d.z = pos_q.z + 32'd1;
                    if (pos_d.z == grid_q.z) begin
                        pos_d.z = '0;
                        pos_d.y = pos_q.y + 32'd1;
                        if (pos_d.y == grid_q.y) begin
                            pos_d.y = '0;
                            pos_d.x = pos_q.x + 32'd1;
                        end
                    end
                    if (last_cta) begin
                        state_d = StDrain;
                    end
                end else if (cta_valid) begin
                    lock_d      = 1'b1;
                    lock_core_d = cta_core;
                end
            end
            StDrain: begin
                if (all_idle) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            grid_q      <= '0;
            pos_q       <= '0;
            id_q        <= '0;
            rr_q        <= '0;
            lock_q      <= 1'b0;
            lock_core_q <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                outstanding_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            grid_q      <= grid_d;
            pos_q       <= pos_d;
            id_q        <= id_d;
            rr_q        <= rr_d;
            lock_q      <= lock_d;
            lock_core_q <= lock_core_d;
            err_q       <= err_d;
            for (int i = 0; i < NUM_CORES; i++) begin
                outstanding_q[i] <= outstanding_d[i];
            end
        end
    end

endmodule

// File: tb/tb_vx_kmu_cta_scheduler.sv
// Bench for the CTA scheduler: directed scenarios plus randomized kernels checked
// against a coordinate/credit model derived from the issue rules.
module tb_vx_kmu_cta_scheduler;

    localparam int unsigned NC   = 4;
    localparam int unsigned MAXC = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          launch_valid, launch_ready, cta_valid, cta_ready;
    logic          kernel_done, busy, err_underflow;
    logic [95:0]   launch_grid;
    logic [1:0]    cta_core;
    logic [31:0]   cta_x, cta_y, cta_z, cta_id;
    logic [NC-1:0] core_retire;

    logic          s_launch_valid, s_launch_ready, s_cta_valid, s_cta_ready;
    logic          s_kernel_done, s_busy, s_err;
    logic [95:0]   s_launch_grid;
    logic [0:0]    s_cta_core;
    logic [31:0]   s_cta_x, s_cta_y, s_cta_z, s_cta_id;
    logic [0:0]    s_core_retire;

    int checks = 0;
    int errors = 0;
    int trk [NC];

    vx_kmu_cta_scheduler #(
        .NUM_CORES         (NC),
        .MAX_CTAS_PER_CORE (MAXC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .launch_valid  (launch_valid),
        .launch_ready  (launch_ready),
        .launch_grid   (launch_grid),
        .cta_valid     (cta_valid),
        .cta_ready     (cta_ready),
        .cta_core      (cta_core),
        .cta_x         (cta_x),
        .cta_y         (cta_y),
        .cta_z         (cta_z),
        .cta_id        (cta_id),
        .core_retire   (core_retire),
        .kernel_done   (kernel_done),
        .busy          (busy),
        .err_underflow (err_underflow)
    );

    vx_kmu_cta_scheduler #(
        .NUM_CORES         (1),
        .MAX_CTAS_PER_CORE (15)
    ) dut1 (
        .clk           (clk),
        .reset         (reset),
        .launch_valid  (s_launch_valid),
        .launch_ready  (s_launch_ready),
        .launch_grid   (s_launch_grid),
        .cta_valid     (s_cta_valid),
        .cta_ready     (s_cta_ready),
        .cta_core      (s_cta_core),
        .cta_x         (s_cta_x),
        .cta_y         (s_cta_y),
        .cta_z         (s_cta_z),
        .cta_id        (s_cta_id),
        .core_retire   (s_core_retire),
        .kernel_done   (s_kernel_done),
        .busy          (s_busy),
        .err_underflow (s_err)
    );

    // Track outstanding CTAs per core from observed traffic; used only to drive retires.
    task automatic tick();
        if (cta_valid && cta_ready) trk[cta_core]++;
        for (int i = 0; i < NC; i++) if (core_retire[i] && trk[i] > 0) trk[i]--;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] gx, input logic [31:0] gy, input logic [31:0] gz);
        launch_valid = 1'b1;
        launch_grid  = {gz, gy, gx};
        #1;
        checks++;
        if (launch_ready !== 1'b1) begin
            errors++; $display("FAIL launch_ready: got %b want 1", launch_ready);
        end
        tick();
        launch_valid = 1'b0;
    endtask

    task automatic finish_kernel(input string name);
        bit seen = 1'b0;
        cta_ready = 1'b1;
        for (int c = 0; c < 200 && !seen; c++) begin
            for (int i = 0; i < NC; i++) core_retire[i] = (trk[i] > 0);
            #1;
            if (kernel_done) seen = 1'b1;
            tick();
        end
        core_retire = '0;
        checks++;
        if (!seen) begin
            errors++; $display("FAIL %s_done: kernel_done got 0 want 1 within 200 cycles", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; launch_valid = 1'b0; launch_grid = '0; cta_ready = 1'b0; core_retire = '0;
        s_launch_valid = 1'b0; s_launch_grid = '0; s_cta_ready = 1'b0; s_core_retire = '0;
        foreach (trk[i]) trk[i] = 0;
        #3;
        checks++;
        if (launch_ready !== 1'b1 || cta_valid !== 1'b0 || kernel_done !== 1'b0 ||
            busy !== 1'b0 || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: ready=%b valid=%b done=%b busy=%b err=%b want 1 0 0 0 0",
                     launch_ready, cta_valid, kernel_done, busy, err_underflow);
        end
        checks++;
        if (cta_id !== 32'd0 || cta_core !== 2'd0 || {cta_x, cta_y, cta_z} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data: id=%0d core=%0d xyz=%0d/%0d/%0d want 0", cta_id, cta_core,
                     cta_x, cta_y, cta_z);
        end
        #10;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        cta_ready = 1'b1;
        launch(32'd1, 32'd1, 32'd3);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cta_valid !== 1'b1 || cta_core !== 2'(k) || cta_z !== 32'(k) ||
                cta_id !== 32'(k) || cta_x !== 32'd0 || cta_y !== 32'd0) begin
                errors++;
                $display("FAIL basic_issue%0d: valid=%b core=%0d z=%0d id=%0d want 1 %0d %0d %0d",
                         k, cta_valid, cta_core, cta_z, cta_id, k, k, k);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (cta_valid !== 1'b0 || busy !== 1'b1 || kernel_done !== 1'b0) begin
                errors++;
                $display("FAIL basic_drain: valid=%b busy=%b done=%b want 0 1 0",
                         cta_valid, busy, kernel_done);
            end
            tick();
        end
        core_retire = 4'b0111;
        #1;
        checks++;
        if (kernel_done !== 1'b0) begin
            errors++; $display("FAIL basic_early_done: got %b want 0", kernel_done);
        end
        tick();
        core_retire = '0;
        checks++;
        if (kernel_done !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL basic_done: done=%b busy=%b want 1 1", kernel_done, busy);
        end
        tick();
        checks++;
        if (kernel_done !== 1'b0 || busy !== 1'b0 || launch_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_idle: done=%b busy=%b ready=%b want 0 0 1",
                     kernel_done, busy, launch_ready);
        end
    endtask

    task automatic test_order();
        logic [95:0] expq[$];
        int n = 0;
        int dones = 0;
        bit prev_hs = 1'b0;
        for (int x = 0; x < 2; x++)
            for (int y = 0; y < 2; y++)
                for (int z = 0; z < 2; z++) expq.push_back({32'(x), 32'(y), 32'(z)});
        s_cta_ready    = 1'b1;
        s_launch_grid  = {32'd2, 32'd2, 32'd2};
        s_launch_valid = 1'b1;
        #1;
        checks++;
        if (s_launch_ready !== 1'b1) begin
            errors++; $display("FAIL order_launch_ready: got %b want 1", s_launch_ready);
        end
        @(posedge clk);
        #1;
        s_launch_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            s_core_retire = prev_hs;
            #1;
            prev_hs = 1'b0;
            if (s_kernel_done) dones++;
            if (s_cta_valid) begin
                checks++;
                if (n >= 8 || {s_cta_x, s_cta_y, s_cta_z} !== expq[n] || s_cta_id !== 32'(n)) begin
                    errors++;
                    $display("FAIL order_cta%0d: xyz=%0d/%0d/%0d id=%0d want %0d/%0d/%0d id %0d",
                             n, s_cta_x, s_cta_y, s_cta_z, s_cta_id, expq[n][95:64],
                             expq[n][63:32], expq[n][31:0], n);
                end
                n++;
                prev_hs = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        s_core_retire = '0;
        checks++;
        if (n != 8 || dones != 1 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL order_totals: ctas=%0d dones=%0d busy=%b want 8 1 0", n, dones, s_busy);
        end
    endtask

    task automatic test_credits();
        int issued = 0;
        cta_ready = 1'b1;
        launch(32'd1, 32'd1, 32'd10);
        for (int c = 0; c < 12; c++) begin
            if (cta_valid) issued++;
            tick();
        end
        checks++;
        if (issued != 8 || cta_valid !== 1'b0) begin
            errors++;
            $display("FAIL credits_limit: issued=%0d valid=%b want 8 0", issued, cta_valid);
        end
        core_retire = 4'b0010;
        #1;
        checks++;
        if (cta_valid !== 1'b0) begin
            errors++; $display("FAIL credits_same_cycle: valid=%b want 0", cta_valid);
        end
        tick();
        core_retire = '0;
        #1;
        checks++;
        if (cta_valid !== 1'b1 || cta_core !== 2'd1 || cta_id !== 32'd8 || cta_z !== 32'd8) begin
            errors++;
            $display("FAIL credits_ninth: valid=%b core=%0d id=%0d z=%0d want 1 1 8 8",
                     cta_valid, cta_core, cta_id, cta_z);
        end
        finish_kernel("credits");
    endtask

    task automatic test_backpressure();
        cta_ready = 1'b1;
        launch(32'd1, 32'd1, 32'd12);
        for (int c = 0; c < 8; c++) tick();
        cta_ready   = 1'b0;
        core_retire = 4'b0010;
        #1;
        tick();
        // core 0 retires while core 1 is held; an unlocked pick would switch to core 0
        for (int h = 0; h < 3; h++) begin
            core_retire = (h == 0) ? 4'b0001 : ((h == 1) ? 4'b1000 : 4'b0000);
            #1;
            checks++;
            if (cta_valid !== 1'b1 || cta_core !== 2'd1 || cta_id !== 32'd8 ||
                cta_z !== 32'd8 || cta_x !== 32'd0 || cta_y !== 32'd0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b core=%0d id=%0d z=%0d want 1 1 8 8",
                         h, cta_valid, cta_core, cta_id, cta_z);
            end
            tick();
        end
        core_retire = '0;
        cta_ready   = 1'b1;
        #1;
        checks++;
        if (cta_valid !== 1'b1 || cta_core !== 2'd1 || cta_id !== 32'd8) begin
            errors++;
            $display("FAIL bp_release: valid=%b core=%0d id=%0d want 1 1 8",
                     cta_valid, cta_core, cta_id);
        end
        tick();
        checks++;
        if (cta_valid !== 1'b1 || cta_core !== 2'd3 || cta_id !== 32'd9 || cta_z !== 32'd9) begin
            errors++;
            $display("FAIL bp_advance: valid=%b core=%0d id=%0d z=%0d want 1 3 9 9",
                     cta_valid, cta_core, cta_id, cta_z);
        end
        finish_kernel("bp");
    endtask

    task automatic test_zero_grid();
        launch(32'd0, 32'd5, 32'd5);
        checks++;
        if (kernel_done !== 1'b1 || cta_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b valid=%b want 1 0", kernel_done, cta_valid);
        end
        tick();
        checks++;
        if (kernel_done !== 1'b0 || busy !== 1'b0 || cta_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: done=%b busy=%b valid=%b want 0 0 0",
                     kernel_done, busy, cta_valid);
        end
        core_retire = 4'b0100;
        #1;
        tick();
        core_retire = '0;
        checks++;
        if (err_underflow !== 1'b1) begin
            errors++; $display("FAIL underflow_set: got %b want 1", err_underflow);
        end
        tick();
        tick();
        checks++;
        if (err_underflow !== 1'b1 || launch_ready !== 1'b1) begin
            errors++;
            $display("FAIL underflow_sticky: err=%b ready=%b want 1 1", err_underflow, launch_ready);
        end
    endtask

    task automatic test_reset_mid();
        cta_ready = 1'b0;
        launch(32'd1, 32'd1, 32'd4);
        checks++;
        if (cta_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_pre: valid=%b want 1", cta_valid);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (cta_valid !== 1'b0 || busy !== 1'b0 || err_underflow !== 1'b0 ||
            launch_ready !== 1'b1 || kernel_done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: valid=%b busy=%b err=%b ready=%b done=%b want 0 0 0 1 0",
                     cta_valid, busy, err_underflow, launch_ready, kernel_done);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        foreach (trk[i]) trk[i] = 0;
        cta_ready = 1'b1;
        launch(32'd1, 32'd1, 32'd1);
        checks++;
        if (cta_valid !== 1'b1 || cta_core !== 2'd0 || cta_id !== 32'd0 ||
            {cta_x, cta_y, cta_z} !== 96'd0) begin
            errors++;
            $display("FAIL midrst_relaunch: valid=%b core=%0d id=%0d want 1 0 0",
                     cta_valid, cta_core, cta_id);
        end
        finish_kernel("midrst");
    endtask

    task automatic test_random();
        int          mout [NC];
        int unsigned rr = 0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        foreach (trk[i]) trk[i] = 0;
        foreach (mout[i]) mout[i] = 0;
        tick();
        for (int k = 0; k < 6; k++) begin
            int unsigned gx, gy, gz, total, nid, offer, phase, ecore;
            bit          have_offer, ev, hs, allz, any_el;
            logic [NC-1:0] ret;
            gx = $urandom_range(1, 3);
            gy = $urandom_range(1, 3);
            gz = $urandom_range(1, 3);
            total = gx * gy * gz;
            nid = 0; offer = 0; phase = 1; have_offer = 1'b0;
            launch(gx, gy, gz);
            for (int c = 0; c < 300 && phase != 0; c++) begin
                cta_ready = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < NC; i++) ret[i] = (mout[i] > 0) && ($urandom_range(0, 2) == 0);
                core_retire = ret;
                #1;
                any_el = 1'b0;
                ecore  = 0;
                if (have_offer) begin
                    any_el = 1'b1;
                    ecore  = offer;
                end else begin
                    for (int j = 0; j < NC; j++) begin
                        if (!any_el && mout[(rr + j) % NC] < MAXC) begin
                            any_el = 1'b1;
                            ecore  = (rr + j) % NC;
                        end
                    end
                end
                ev = (phase == 1) && any_el;
                checks++;
                if (cta_valid !== ev) begin
                    errors++;
                    $display("FAIL rnd%0d_valid: got %b want %b (cycle %0d)", k, cta_valid, ev, c);
                end
                if (ev) begin
                    checks++;
                    if (cta_core !== 2'(ecore) || cta_id !== nid || cta_z !== nid % gz ||
                        cta_y !== (nid / gz) % gy || cta_x !== nid / (gz * gy)) begin
                        errors++;
                        $display("FAIL rnd%0d_cta: core=%0d id=%0d xyz=%0d/%0d/%0d want %0d %0d %0d/%0d/%0d",
                                 k, cta_core, cta_id, cta_x, cta_y, cta_z, ecore, nid,
                                 nid / (gz * gy), (nid / gz) % gy, nid % gz);
                    end
                end
                checks++;
                if (kernel_done !== (phase == 3) || busy !== (phase != 0)) begin
                    errors++;
                    $display("FAIL rnd%0d_status: done=%b busy=%b want %b %b", k, kernel_done,
                             busy, (phase == 3), (phase != 0));
                end
                hs = ev && cta_ready;
                if (hs) mout[ecore]++;
                for (int i = 0; i < NC; i++) if (ret[i]) mout[i]--;
                allz = 1'b1;
                for (int i = 0; i < NC; i++) if (mout[i] != 0) allz = 1'b0;
                case (phase)
                    1: begin
                        if (hs) begin
                            rr = (ecore + 1) % NC;
                            nid++;
                            have_offer = 1'b0;
                            if (nid == total) phase = 2;
                        end else if (ev) begin
                            have_offer = 1'b1;
                            offer      = ecore;
                        end
                    end
                    2: if (allz) phase = 3;
                    default: phase = 0;
                endcase
                tick();
            end
            core_retire = '0;
            checks++;
            if (phase != 0) begin
                errors++; $display("FAIL rnd%0d_timeout: model phase %0d want 0", k, phase);
            end
        end
        checks++;
        if (err_underflow !== 1'b0) begin
            errors++; $display("FAIL rnd_err: got %b want 0", err_underflow);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_order();
        test_credits();
        test_backpressure();
        test_zero_grid();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/vx_kmu_cta_scheduler.md
Name: vx_kmu_cta_scheduler

Overview:
- Sequences CTA dispatch for one kernel launch from the KMU to the cores.
- Walks the grid in z-fastest, then y, then x order.
- Picks a target core by round-robin among cores with free CTA slots (credits), issues one CTA per cycle over a valid/ready port, and tracks retirements.
- Pulses kernel_done once all CTAs have been issued and retired. Sits between the KMU task FIFO output and the per-core task interfaces.

Parameters:
NUM_CORES, 4, number of cores served (1..64)
MAX_CTAS_PER_CORE, 2, outstanding-CTA credit limit per core (1..15)
CORE_IDW, `CLOG2(NUM_CORES) (minimum 1), width of core index

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset (0 = in reset)
launch_valid  in  1  new kernel descriptor available
launch_ready  out  1  scheduler can accept a launch
launch_grid  in  96  grid dims {z[95:64], y[63:32], x[31:0]}
cta_valid  out  1  CTA offered
cta_ready  in  1  selected core accepts CTA
cta_core  out  CORE_IDW  target core index
cta_x  out  32  CTA x coordinate
cta_y  out  32  CTA y coordinate
cta_z  out  32  CTA z coordinate
cta_id  out  32  linear CTA index (issue order)
core_retire  in  NUM_CORES  per-core one-cycle pulse: one CTA finished
kernel_done  out  1  one-cycle pulse: launch complete
busy  out  1  state != IDLE
err_underflow  out  1  sticky: retire seen with zero outstanding

Behaviour:
- Reset (async assert, sync release): state IDLE, all counters/outstanding/rr pointer/lock = 0, err_underflow = 0. Outputs: launch_ready = 1, all other outputs 0.
- FSM: IDLE, DISPATCH, DRAIN, DONE.
- IDLE:
  - launch_ready = 1.
  - On launch_valid, latch grid dims. Any dim == 0 -> DONE; else clear x/y/z/id counters -> DISPATCH.
  - First cta_valid is one cycle after acceptance.
- DISPATCH:
  - eligible[i] = outstanding[i] < MAX_CTAS_PER_CORE.
  - When no CTA is locked, grant = first eligible core at or after rr_ptr (wrapping). cta_valid = |eligible.
  - Once cta_valid is high without cta_ready, cta_core and the coordinates are locked and must stay stable until the handshake.
  - Handshake (cta_valid & cta_ready):
    - outstanding[cta_core]++, rr_ptr = cta_core+1 mod NUM_CORES, id++.
    - z++; if z == gz then z = 0, y++; if y == gy then y = 0, x++.
  - Last-CTA detection is by coordinates (x == gx-1, y == gy-1, z == gz-1), never by the product. Issuing the last CTA -> DRAIN.
  - Counters and cta_id are 32 bit; cta_id wraps modulo 2^32.
- DRAIN: cta_valid = 0. When all outstanding == 0 (retires of the current cycle included) -> DONE.
- DONE: kernel_done = 1 for exactly one cycle -> IDLE. The next launch can be accepted the cycle after.
- launch_ready = 0 in every state except IDLE.
- Retire accounting applies in every state:
  - Same-cycle issue and retire on one core leaves outstanding unchanged. A core at the limit that retires is not eligible until the following cycle (eligibility uses registered counts).
  - A retire with outstanding == 0 is ignored and sets err_underflow; only reset clears it.
- Reset mid-operation aborts the launch. No kernel_done is produced and state is discarded.

Decomposition:
- VX_gpu_pkg holds:
  - kmu_cta_state_e (IDLE/DISPATCH/DRAIN/DONE)
  - kmu_grid_t struct {x, y, z} 32 bit each
  - KMU_CTA_CRED_W = `CLOG2(MAX_CTAS_PER_CORE+1)
- One sub-module: vx_kmu_rr_pick, a combinational round-robin first-eligible selector.
  - Inputs: eligible vector, rr_ptr.
  - Outputs: grant index, any.

Test Plan:
1. NUM_CORES=4, grid (x1,y1,z3), cta_ready=1, launch at T:
   - cta_valid at T+1..T+3 to cores 0,1,2 with z=0,1,2 and id 0,1,2.
   - Then DRAIN; retire cores 0,1,2 at T+6 -> kernel_done at T+7, busy low at T+8.
2. Grid (2,2,2), 1 core, MAX=15, retire each CTA the cycle after issue:
   - Coordinate order (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0)…(1,1,1), ids 0..7.
   - One kernel_done.
3. Credits: 4 cores, MAX=2, grid (1,1,10), no retires:
   - Exactly 8 CTAs issued, then cta_valid = 0.
   - Pulse core_retire[1] -> 9th CTA offered next cycle with cta_core = 1.
4. Backpressure: hold cta_ready = 0 for 3 cycles while cta_valid = 1 and retires arrive on other cores.
   - cta_core, cta_x/y/z, cta_id remain stable.
   - On release, the handshake occurs and outputs advance.
5. Grid (0,5,5) -> no cta_valid ever, kernel_done at T+1.
   - Retire pulse on core 2 in IDLE -> err_underflow = 1 and stays 1.
6. Assert reset mid-DISPATCH with cta_valid high -> outputs 0 immediately (asynchronous).
   - After release, a new launch of grid (1,1,1) issues id 0 to core 0.
